// File: rtl/if_pkg.sv
// Shared widths, constants and state encoding for the instruction-fetch stage.
package if_pkg;

  localparam int PC_W    = 13;
  localparam int INSTR_W = 32;

  // Bubble loaded into IF/ID on a flush.
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HELD    = 2'd2,
    DISCARD = 2'd3
  } if_state_e;

  // PC advance, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc4(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry skid buffer: parks a fetched instruction and its PC+4 while ID
// is stalled, so a memory response accepted during a stall is never lost.
module if_skid_buf
  import if_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc4_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc4_out,
  output logic               valid_out
);

  logic               valid_d, valid_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [PC_W-1:0]    pc4_d, pc4_q;

  // Next-entry selection; clear wins over load.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc4_d   = pc4_in;
    end
  end

  // Only the valid bit needs a reset; payload is ignored while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload registers.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc4_q   <= pc4_d;
  end

  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch controller: owns the PC, handshakes with instruction
// memory and drives the IF/ID load/bubble strobes, handling ID stalls and
// branch redirects (including redirects while a fetch is still outstanding).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 13'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_in,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               hold,
  output logic               IF_flush,
  output logic [INSTR_W-1:0] instruc_out,
  output logic [PC_W-1:0]    PC_plus_4_out
);

  if_state_e          state_d, state_q;
  logic [PC_W-1:0]    pc_d, pc_q;
  // Address of the fetch still in flight when a redirect arrived.
  logic [PC_W-1:0]    old_addr_d, old_addr_q;

  logic               redirect;
  logic               skid_load, skid_clr, skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc4;

  // A stalled ID re-presents its branch later, so stall masks the redirect.
  assign redirect = branch_taken & ~stall_in;

  if_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clr       (skid_clr),
    .instr_in  (imem_rdata),
    .pc4_in    (pc_inc4(pc_q)),
    .instr_out (skid_instr),
    .pc4_out   (skid_pc4),
    .valid_out (skid_valid)
  );

  // Next-state, PC update and combinational IF/ID / memory outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    old_addr_d    = old_addr_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;
    hold          = 1'b0;
    IF_flush      = 1'b0;
    instruc_out   = NOP;
    PC_plus_4_out = pc_inc4(pc_q);
    skid_load     = 1'b0;
    skid_clr      = 1'b0;

    case (state_q)
      BOOT: begin
        // IF/ID has no reset of its own; bubble it once.
        IF_flush = 1'b1;
        state_d  = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          IF_flush = 1'b1;
          pc_d     = branch_target;
          skid_clr = 1'b1;
          if (!imem_ready) begin
            old_addr_d = pc_q;
            state_d    = DISCARD;
          end
        end else if (imem_ready && !stall_in) begin
          hold        = 1'b1;
          instruc_out = imem_rdata;
          pc_d        = pc_inc4(pc_q);
        end else if (imem_ready) begin
          // ID stalled while the response arrives: park it, no refetch.
          skid_load = 1'b1;
          state_d   = HELD;
        end else begin
          IF_flush = ~stall_in;
        end
      end

      HELD: begin
        if (redirect) begin
          IF_flush = 1'b1;
          pc_d     = branch_target;
          skid_clr = 1'b1;
          state_d  = FETCH;
        end else if (!stall_in) begin
          hold          = 1'b1;
          instruc_out   = skid_valid ? skid_instr : NOP;
          PC_plus_4_out = skid_pc4;
          pc_d          = pc_inc4(pc_q);
          skid_clr      = 1'b1;
          state_d       = FETCH;
        end
      end

      DISCARD: begin
        // Keep the stale request stable until memory answers, then drop it.
        imem_req  = 1'b1;
        imem_addr = old_addr_q;
        IF_flush  = ~stall_in;
        if (redirect) begin
          pc_d     = branch_target;
          skid_clr = 1'b1;
        end
        if (imem_ready) state_d = FETCH;
      end

      default: state_d = BOOT;
    endcase
  end

  // State, PC and stale-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      old_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      old_addr_q <= old_addr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: each stimulus cycle pushes the
// hand-computed expected outputs; a monitor pops and compares at negedge.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        branch_taken;
  logic [12:0] branch_target;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        hold;
  logic        IF_flush;
  logic [31:0] instruc_out;
  logic [12:0] PC_plus_4_out;

  typedef struct packed {
    logic [7:0]  id;
    logic        req;
    logic [12:0] addr;
    logic        hold;
    logic        flush;
    logic        chk;
    logic [31:0] instr;
    logic [12:0] pc4;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] step_id = 8'd0;

  if_fetch_unit #(.RESET_PC(13'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_in      (stall_in),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .hold          (hold),
    .IF_flush      (IF_flush),
    .instruc_out   (instruc_out),
    .PC_plus_4_out (PC_plus_4_out)
  );

  always #5 clk = ~clk;

  // Memory model: data only meaningful for an active request.
  assign imem_rdata = imem_req ? (32'h1000_0000 + {19'h0, imem_addr}) : 32'hDEAD_BEEF;

  task automatic step(input logic rn, input logic st, input logic br,
                      input logic [12:0] tgt, input logic rdy,
                      input logic e_req, input logic [12:0] e_addr,
                      input logic e_hold, input logic e_flush, input logic e_chk,
                      input logic [31:0] e_instr, input logic [12:0] e_pc4);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = rn;
    stall_in      = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    e.id    = step_id;
    e.req   = e_req;
    e.addr  = e_addr;
    e.hold  = e_hold;
    e.flush = e_flush;
    e.chk   = e_chk;
    e.instr = e_instr;
    e.pc4   = e_pc4;
    q.push_back(e);
    step_id = step_id + 8'd1;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({imem_req, imem_addr, hold, IF_flush} !== {e.req, e.addr, e.hold, e.flush}) begin
          n_fail++;
          $display("FAIL ctrl step %0d: got req=%b addr=%h hold=%b flush=%b, want req=%b addr=%h hold=%b flush=%b",
                   e.id, imem_req, imem_addr, hold, IF_flush, e.req, e.addr, e.hold, e.flush);
        end
        if (e.chk) begin
          n_checks++;
          if ({instruc_out, PC_plus_4_out} !== {e.instr, e.pc4}) begin
            n_fail++;
            $display("FAIL data step %0d: got instr=%h pc4=%h, want instr=%h pc4=%h",
                     e.id, instruc_out, PC_plus_4_out, e.instr, e.pc4);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; branch_taken = 1'b0;
    branch_target = 13'h0; imem_ready = 1'b0;

    //   rn st br tgt       rdy  req addr      hold flush chk instr          pc4
    step(0, 0, 0, 13'h0000, 0,   0, 13'h0000, 0,   1,    1,  32'h0,         13'h0004); // in reset
    step(1, 0, 0, 13'h0000, 1,   0, 13'h0000, 0,   1,    1,  32'h0,         13'h0004); // BOOT
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0000, 1,   0,    1,  32'h1000_0000, 13'h0004);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0004, 1,   0,    1,  32'h1000_0004, 13'h0008);
    // stall 3 cycles with ready at pc=8
    step(1, 1, 0, 13'h0000, 1,   1, 13'h0008, 0,   0,    0,  32'h0,         13'h0000);
    step(1, 1, 0, 13'h0000, 1,   0, 13'h0008, 0,   0,    0,  32'h0,         13'h0000);
    step(1, 1, 0, 13'h0000, 1,   0, 13'h0008, 0,   0,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   0, 13'h0008, 1,   0,    1,  32'h1000_0008, 13'h000C);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h000C, 1,   0,    1,  32'h1000_000C, 13'h0010);
    // redirect with ready at pc=16
    step(1, 0, 1, 13'h0100, 1,   1, 13'h0010, 0,   1,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0100, 1,   0,    1,  32'h1000_0100, 13'h0104);
    // redirect during wait -> DISCARD
    step(1, 0, 1, 13'h0200, 0,   1, 13'h0104, 0,   1,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 0,   1, 13'h0104, 0,   1,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0104, 0,   1,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0200, 1,   0,    1,  32'h1000_0200, 13'h0204);
    // branch while stalled is ignored
    step(1, 1, 1, 13'h0300, 0,   1, 13'h0204, 0,   0,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0204, 1,   0,    1,  32'h1000_0204, 13'h0208);
    // PC wrap
    step(1, 0, 1, 13'h1FFC, 1,   1, 13'h0208, 0,   1,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h1FFC, 1,   0,    1,  32'h1000_1FFC, 13'h0000);
    step(1, 0, 0, 13'h0000, 0,   1, 13'h0000, 0,   1,    0,  32'h0,         13'h0000);
    // reset mid-wait
    step(0, 0, 0, 13'h0000, 0,   0, 13'h0000, 0,   1,    1,  32'h0,         13'h0004);
    step(1, 0, 0, 13'h0000, 1,   0, 13'h0000, 0,   1,    1,  32'h0,         13'h0004);
    // redirect out of HELD
    step(1, 1, 0, 13'h0000, 1,   1, 13'h0000, 0,   0,    0,  32'h0,         13'h0000);
    step(1, 0, 1, 13'h0040, 1,   0, 13'h0000, 0,   1,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0040, 1,   0,    1,  32'h1000_0040, 13'h0044);
    // DISCARD with stall suppresses the bubble
    step(1, 0, 1, 13'h0080, 0,   1, 13'h0044, 0,   1,    0,  32'h0,         13'h0000);
    step(1, 1, 0, 13'h0000, 0,   1, 13'h0044, 0,   0,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0044, 0,   1,    0,  32'h0,         13'h0000);
    step(1, 0, 0, 13'h0000, 1,   1, 13'h0080, 1,   0,    1,  32'h1000_0080, 13'h0084);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
